// File: rtl/maf_channel_scheduler.sv
// Shared moving-average datapath time-multiplexed across NUM_CH sample streams.
// Each channel owns an N-deep circular window, a running sum and a fill count.
// A round-robin arbiter accepts at most one sample per cycle, and the updated
// channel average is registered together with its channel index.
//
// Ports:
//   clk        system clock, rising edge
//   areset     asynchronous reset, active-high
//   in_valid   per-channel sample valid
//   in_data    packed samples, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_ready   one-hot grant (combinational)
//   ch_clear   synchronous per-channel state clear
//   out_valid  result valid
//   out_ready  downstream ready
//   out_data   floor(window sum / N)
//   out_ch     channel index of out_data
//   out_warm   window of out_ch held N real samples at this result
module maf_channel_scheduler #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned N          = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           areset,
    input  logic [NUM_CH-1:0]              in_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   in_data,
    output logic [NUM_CH-1:0]              in_ready,
    input  logic [NUM_CH-1:0]              ch_clear,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [$clog2(NUM_CH)-1:0]      out_ch,
    output logic                           out_warm
);

    localparam int unsigned CH_W   = $clog2(NUM_CH);
    localparam int unsigned IDX_W  = $clog2(N);
    localparam int unsigned SUM_W  = DATA_WIDTH + IDX_W;
    localparam int unsigned FILL_W = $clog2(N + 1);

    // Per-channel state
    logic [DATA_WIDTH-1:0] buf_q  [NUM_CH][N];
    logic [DATA_WIDTH-1:0] buf_d  [NUM_CH][N];
    logic [SUM_W-1:0]      sum_q  [NUM_CH];
    logic [SUM_W-1:0]      sum_d  [NUM_CH];
    logic [FILL_W-1:0]     fill_q [NUM_CH];
    logic [FILL_W-1:0]     fill_d [NUM_CH];
    logic [IDX_W-1:0]      widx_q [NUM_CH];
    logic [IDX_W-1:0]      widx_d [NUM_CH];

    // Arbiter pointer and output register
    logic [CH_W-1:0]       ptr_q, ptr_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [CH_W-1:0]       out_ch_q, out_ch_d;
    logic                  out_warm_q, out_warm_d;

    // Arbitration / datapath intermediates
    logic [NUM_CH-1:0]     eligible_c;
    logic                  gnt_found_c;
    logic [CH_W-1:0]       gnt_idx_c;
    int unsigned           arb_idx_c;
    logic                  can_accept_c;
    logic                  accept_c;
    logic [DATA_WIDTH-1:0] sample_c;
    logic [DATA_WIDTH-1:0] oldest_c;
    logic [SUM_W-1:0]      new_sum_c;
    logic [FILL_W-1:0]     new_fill_c;

    // Round-robin search upward from ptr_q; a cleared channel is never eligible.
    always_comb begin
        eligible_c  = in_valid & ~ch_clear;
        gnt_found_c = 1'b0;
        gnt_idx_c   = '0;
        arb_idx_c   = 0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            arb_idx_c = 32'(ptr_q) + k;
            if (arb_idx_c >= NUM_CH) begin
                arb_idx_c = arb_idx_c - NUM_CH;
            end
            if (!gnt_found_c && eligible_c[arb_idx_c]) begin
                gnt_found_c = 1'b1;
                gnt_idx_c   = CH_W'(arb_idx_c);
            end
        end
    end

    // Grant only when the output register is free or draining this cycle.
    always_comb begin
        can_accept_c = !out_valid_q || out_ready;
        accept_c     = gnt_found_c && can_accept_c && !areset;
        in_ready     = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (accept_c && (gnt_idx_c == CH_W'(i))) begin
                in_ready[i] = 1'b1;
            end
        end
    end

    // Granted channel's new sum and fill; sum never underflows as it contains oldest.
    always_comb begin
        sample_c  = in_data[32'(gnt_idx_c) * DATA_WIDTH +: DATA_WIDTH];
        oldest_c  = buf_q[gnt_idx_c][widx_q[gnt_idx_c]];
        new_sum_c = sum_q[gnt_idx_c] - SUM_W'(oldest_c) + SUM_W'(sample_c);
        if (fill_q[gnt_idx_c] == FILL_W'(N)) begin
            new_fill_c = fill_q[gnt_idx_c];
        end else begin
            new_fill_c = fill_q[gnt_idx_c] + FILL_W'(1);
        end
    end

    // Next state for channel windows, pointer and output register.
    always_comb begin
        buf_d       = buf_q;
        sum_d       = sum_q;
        fill_d      = fill_q;
        widx_d      = widx_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_warm_d  = out_warm_q;

        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_clear[i]) begin
                for (int unsigned j = 0; j < N; j++) begin
                    buf_d[i][j] = '0;
                end
                sum_d[i]  = '0;
                fill_d[i] = '0;
                widx_d[i] = '0;
            end else if (accept_c && (gnt_idx_c == CH_W'(i))) begin
                buf_d[i][widx_q[i]] = sample_c;
                sum_d[i]            = new_sum_c;
                fill_d[i]           = new_fill_c;
                // N is a power of two, so the index wraps naturally.
                widx_d[i]           = widx_q[i] + IDX_W'(1);
            end
        end

        if (accept_c) begin
            if (32'(gnt_idx_c) == NUM_CH - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx_c + CH_W'(1);
            end
            out_valid_d = 1'b1;
            out_data_d  = DATA_WIDTH'(new_sum_c >> IDX_W);
            out_ch_d    = gnt_idx_c;
            out_warm_d  = (new_fill_c == FILL_W'(N));
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                for (int unsigned j = 0; j < N; j++) begin
                    buf_q[i][j] <= '0;
                end
                sum_q[i]  <= '0;
                fill_q[i] <= '0;
                widx_q[i] <= '0;
            end
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_warm_q  <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            sum_q       <= sum_d;
            fill_q      <= fill_d;
            widx_q      <= widx_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_warm_q  <= out_warm_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_warm  = out_warm_q;

endmodule

// File: tb/tb_maf_channel_scheduler.sv
// Directed table-driven bench for maf_channel_scheduler (NUM_CH=4, N=4, DATA_WIDTH=8).
module tb_maf_channel_scheduler;

    logic        clk;
    logic        areset;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic [3:0]  ch_clear;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_warm;

    maf_channel_scheduler #(.NUM_CH(4), .N(4), .DATA_WIDTH(8)) dut (
        .clk       (clk),
        .areset    (areset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .ch_clear  (ch_clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_warm  (out_warm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  vld;
        logic [31:0] data;
        logic [3:0]  clr;
        logic        rdy;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [7:0]  exp_od;
        logic [1:0]  exp_ch;
        logic        exp_w;
    } vec_t;

    localparam int NV    = 36;
    localparam int SPLIT = 10;

    vec_t vecs [NV];
    int   n_checks;
    int   n_fail;

    function automatic logic [31:0] pk(input logic [7:0] d3, input logic [7:0] d2,
                                       input logic [7:0] d1, input logic [7:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    function automatic vec_t mk(input logic [3:0] vld, input logic [31:0] data,
                                input logic [3:0] clr, input logic rdy,
                                input logic [3:0] exp_rdy, input logic exp_ov,
                                input logic [7:0] exp_od, input logic [1:0] exp_ch,
                                input logic exp_w);
        vec_t v;
        v.vld = vld; v.data = data; v.clr = clr; v.rdy = rdy;
        v.exp_rdy = exp_rdy; v.exp_ov = exp_ov; v.exp_od = exp_od;
        v.exp_ch = exp_ch; v.exp_w = exp_w;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input int j);
        @(negedge clk);
        areset    = 1'b0;
        in_valid  = vecs[j].vld;
        in_data   = vecs[j].data;
        ch_clear  = vecs[j].clr;
        out_ready = vecs[j].rdy;
        #1;
        chk($sformatf("v%0d in_ready", j), 32'(in_ready), 32'(vecs[j].exp_rdy));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d out_valid", j), 32'(out_valid), 32'(vecs[j].exp_ov));
        if (vecs[j].exp_ov) begin
            chk($sformatf("v%0d out_data", j), 32'(out_data), 32'(vecs[j].exp_od));
            chk($sformatf("v%0d out_ch", j), 32'(out_ch), 32'(vecs[j].exp_ch));
            chk($sformatf("v%0d out_warm", j), 32'(out_warm), 32'(vecs[j].exp_w));
        end
    endtask

    initial begin
        int k;
        n_checks = 0;
        n_fail   = 0;

        // Single channel 0: 8,16,24,32,40 -> 2,6,12,20,28
        vecs[0] = mk(4'b0001, pk(0, 0, 0, 8),  4'b0, 1'b1, 4'b0001, 1'b1, 8'd2,  2'd0, 1'b0);
        vecs[1] = mk(4'b0001, pk(0, 0, 0, 16), 4'b0, 1'b1, 4'b0001, 1'b1, 8'd6,  2'd0, 1'b0);
        vecs[2] = mk(4'b0001, pk(0, 0, 0, 24), 4'b0, 1'b1, 4'b0001, 1'b1, 8'd12, 2'd0, 1'b0);
        vecs[3] = mk(4'b0001, pk(0, 0, 0, 32), 4'b0, 1'b1, 4'b0001, 1'b1, 8'd20, 2'd0, 1'b1);
        vecs[4] = mk(4'b0001, pk(0, 0, 0, 40), 4'b0, 1'b1, 4'b0001, 1'b1, 8'd28, 2'd0, 1'b1);
        // Idle with ready: output drains
        vecs[5] = mk(4'b0000, 32'd0,           4'b0, 1'b1, 4'b0000, 1'b0, 8'd0,  2'd0, 1'b0);
        // Channel 2 all-max: 63,127,191,255
        vecs[6] = mk(4'b0100, pk(0, 255, 0, 0), 4'b0, 1'b1, 4'b0100, 1'b1, 8'd63,  2'd2, 1'b0);
        vecs[7] = mk(4'b0100, pk(0, 255, 0, 0), 4'b0, 1'b1, 4'b0100, 1'b1, 8'd127, 2'd2, 1'b0);
        vecs[8] = mk(4'b0100, pk(0, 255, 0, 0), 4'b0, 1'b1, 4'b0100, 1'b1, 8'd191, 2'd2, 1'b0);
        vecs[9] = mk(4'b0100, pk(0, 255, 0, 0), 4'b0, 1'b1, 4'b0100, 1'b1, 8'd255, 2'd2, 1'b1);
        // After reset: all channels, ch k fed 4k; avg after r+1 samples = k*(r+1)
        for (int j = 0; j < 16; j++) begin
            int ch;
            int r;
            ch = j % 4;
            r  = j / 4;
            vecs[SPLIT + j] = mk(4'b1111, pk(12, 8, 4, 0), 4'b0, 1'b1,
                                 4'(1 << ch), 1'b1, 8'(ch * (r + 1)), 2'(ch), (r == 3));
        end
        // Backpressure: 5 held cycles of ch3 result 12, then resume at ch0
        for (int j = 0; j < 5; j++) begin
            vecs[26 + j] = mk(4'b1111, pk(12, 8, 4, 0), 4'b0, 1'b0, 4'b0000, 1'b1, 8'd12, 2'd3, 1'b1);
        end
        vecs[31] = mk(4'b1111, pk(12, 8, 4, 0), 4'b0, 1'b1, 4'b0001, 1'b1, 8'd0, 2'd0, 1'b1);
        // Clear ch1 while valid: no grant; next sample 100 -> 25, not warm
        vecs[32] = mk(4'b0010, pk(0, 0, 100, 0), 4'b0010, 1'b1, 4'b0000, 1'b0, 8'd0,  2'd0, 1'b0);
        vecs[33] = mk(4'b0010, pk(0, 0, 100, 0), 4'b0000, 1'b1, 4'b0010, 1'b1, 8'd25, 2'd1, 1'b0);
        // Clear ch2 skips it in RR (ptr=2 -> ch3); ch2 then restarts from empty
        vecs[34] = mk(4'b1111, pk(12, 8, 4, 0), 4'b0100, 1'b1, 4'b1000, 1'b1, 8'd12, 2'd3, 1'b1);
        vecs[35] = mk(4'b0100, pk(0, 8, 0, 0),  4'b0000, 1'b1, 4'b0100, 1'b1, 8'd2,  2'd2, 1'b0);

        // Power-on reset
        areset    = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        ch_clear  = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_data", 32'(out_data), 32'd0);
        chk("rst out_ch", 32'(out_ch), 32'd0);
        chk("rst out_warm", 32'(out_warm), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd0);

        for (int j = 0; j < SPLIT; j++) begin
            run_vec(j);
        end

        // Reset mid-traffic while a result is pending
        @(negedge clk);
        in_valid  = 4'b1111;
        in_data   = pk(12, 8, 4, 0);
        out_ready = 1'b1;
        areset    = 1'b1;
        #1;
        chk("midrst in_ready", 32'(in_ready), 32'd0);
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst out_data", 32'(out_data), 32'd0);
        chk("midrst out_ch", 32'(out_ch), 32'd0);
        @(posedge clk);
        #1;
        chk("midrst held out_valid", 32'(out_valid), 32'd0);

        for (int j = SPLIT; j < NV; j++) begin
            run_vec(j);
        end

        k = 0;
        @(negedge clk);
        in_valid = '0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
